phy_rx_deinterleaver: RTL and testbench
=======================================

// Module: phy_rx_deinterleaver
// PURPOSE
//   Receive-side inverse of the 802.11a block interleaver.
//   - Accepts hard-decision coded bits serially, one per cycle at most, from the demapper.
//   - Reorders each OFDM symbol of N_CBPS bits back into encoder order.
//   - Streams the reordered bits to the Viterbi decoder.
//   - Uses ping-pong symbol buffers, so input and output overlap with no backpressure.
// PARAMETERS
//   MAX_NCBPS  288  largest coded bits per symbol (64-QAM); sets buffer depth
//   ADDR_W     9    buffer address width; must satisfy 2**ADDR_W >= MAX_NCBPS
// PORTS
//   clock           in   1  system clock; all logic on rising edge
//   reset           in   1  asynchronous, active-low reset
//   frame_start     in   1  one-cycle pulse, coincident with the first bit of a frame
//   rate            in   4  802.11a RATE code; sampled only when frame_start=1
//   data_in         in   1  coded bit, valid when data_in_valid=1
//   data_in_valid   in   1  input strobe; no backpressure
//   data_out        out  1  deinterleaved bit, registered
//   data_out_valid  out  1  data_out qualifier, registered
//   symbol_done     out  1  pulse on the last output bit of each symbol
//   rate_err        out  1  sticky; set when an unsupported rate is sampled, cleared by next frame_start
// BEHAVIOUR
//   Reset: every output is 0, both banks are empty, counters are 0, wr_bank=0, rd_bank=0.
//   Rate decode (latched into ncbps, s):
//     1101/1111 -> 48, s=1     0101/0111 -> 96, s=1
//     1001/1011 -> 192, s=2    0001/0011 -> 288, s=3
//     any other code -> rate_err=1; all input is ignored until the next frame_start.
//   Write side:
//     - wr_cnt j counts 0..ncbps-1 on each data_in_valid.
//     - The bit is stored at buf[wr_bank][k(j)].
//     - When j=ncbps-1: mark full[wr_bank], toggle wr_bank, set wr_cnt=0.
//   Inverse mapping, for received index j -> original index k:
//     - i = s*floor(j/s) + (j + floor(16*j/ncbps)) mod s
//     - k = 16*i - (ncbps-1)*floor(16*i/ncbps)
//     - Internal widths are at least 13 bits; the result is in 0..ncbps-1.
//   Read side, states IDLE and READ:
//     - IDLE -> READ when full[rd_bank]=1. rd_cnt=0.
//     - READ: output buf[rd_bank][rd_cnt], one bit per cycle, sequential address.
//     - At rd_cnt=ncbps-1: clear full[rd_bank], pulse symbol_done, toggle rd_bank.
//       Go to READ again if the other bank is full, otherwise go to IDLE.
//   Latency:
//     - Last input bit of a symbol sampled at edge E.
//     - First data_out_valid=1 in the cycle after edge E+2.
//     - Output runs ncbps consecutive cycles with no gaps.
//   Back-to-back symbols: gap-free output when input is continuous. Overflow cannot occur
//     because the reader frees a bank no later than the writer needs it again.
//   Simultaneous full-set and full-clear on the same bank in one cycle: the clear wins for
//     the bank being read; the set applies to the other bank. The two are always different banks.
//   frame_start while busy (mid-frame abort):
//     - Discard all buffered and partial symbols: full=0, counters=0, both banks=0, FSM->IDLE.
//     - data_out_valid goes low from the next cycle.
//     - The current cycle's bit is written as j=0 of the new frame under the new rate.
//   rate changes while frame_start=0 are ignored.
//   Partial symbol at frame end: held, never output; discarded at the next frame_start.
//   Reset asserted mid-operation: immediate return to reset state; no output glitch after release.
// STRUCTURE
//   - Shared header phy_params.vh: RATE code constants, NCBPS_*, and the s value per modulation.
//     Shared with the TX interleaver.
//   - Sub-module deint_addr_gen: combinational (j, ncbps, s) -> k. Reused as the
//     reference model in the bench.
//   - Top level: rate latch, write counter, two MAX_NCBPS-bit reg banks, read FSM,
//     output registers.
// TESTING
//   1. rate=1101, one 48-bit symbol, single 1 at j=1 -> one output 1 at k=16;
//      valid high 48 cycles; symbol_done on the 48th cycle.
//   2. rate=1011 (ncbps=192), single 1 at j=12 -> output 1 only at k=17;
//      single 1 at j=2 -> output 1 at k=32.
//   3. rate=0001, 3 back-to-back 288-bit symbols of random data fed through the TX interleaver
//      model -> output equals the original bits; 864 contiguous valid cycles.
//   4. Input with random valid gaps (50% duty), rate=0101 -> output matches the model;
//      each symbol is emitted gap-free, 2 cycles after its last bit.
//   5. frame_start at bit 100 of a 192-bit symbol -> no output from the aborted frame;
//      the new frame decodes correctly at the new rate.
//   6. rate=0000 -> rate_err=1, no data_out_valid.
//      Then reset low for 3 cycles mid-READ -> all outputs 0 and remain 0 after release.

Source files
------------

// File: rtl/phy_rx_deinterleaver_pkg.sv
// Shared types and constants for the 802.11a receive deinterleaver:
// RATE codes, coded bits per symbol and column-rotation span per modulation.
package phy_rx_deinterleaver_pkg;

   localparam int MAX_NCBPS_DEF = 288;
   localparam int ADDR_W_DEF    = 9;
   localparam int CALC_W        = 13;

   localparam logic [3:0] RATE_6  = 4'b1101;
   localparam logic [3:0] RATE_9  = 4'b1111;
   localparam logic [3:0] RATE_12 = 4'b0101;
   localparam logic [3:0] RATE_18 = 4'b0111;
   localparam logic [3:0] RATE_24 = 4'b1001;
   localparam logic [3:0] RATE_36 = 4'b1011;
   localparam logic [3:0] RATE_48 = 4'b0001;
   localparam logic [3:0] RATE_54 = 4'b0011;

   localparam logic [8:0] NCBPS_BPSK  = 9'd48;
   localparam logic [8:0] NCBPS_QPSK  = 9'd96;
   localparam logic [8:0] NCBPS_16QAM = 9'd192;
   localparam logic [8:0] NCBPS_64QAM = 9'd288;

   localparam logic [1:0] S_BPSK  = 2'd1;
   localparam logic [1:0] S_QPSK  = 2'd1;
   localparam logic [1:0] S_16QAM = 2'd2;
   localparam logic [1:0] S_64QAM = 2'd3;

   typedef enum logic {ST_IDLE, ST_READ} rd_state_t;

   typedef struct packed {
      logic       ok;
      logic [8:0] ncbps;
      logic [1:0] s;
   } rate_cfg_t;

   function automatic rate_cfg_t decode_rate(input logic [3:0] rate);
      rate_cfg_t cfg;
      cfg.ok = 1'b1;
      case (rate)
         RATE_6,  RATE_9:  begin cfg.ncbps = NCBPS_BPSK;  cfg.s = S_BPSK;  end
         RATE_12, RATE_18: begin cfg.ncbps = NCBPS_QPSK;  cfg.s = S_QPSK;  end
         RATE_24, RATE_36: begin cfg.ncbps = NCBPS_16QAM; cfg.s = S_16QAM; end
         RATE_48, RATE_54: begin cfg.ncbps = NCBPS_64QAM; cfg.s = S_64QAM; end
         default:          begin cfg.ok = 1'b0; cfg.ncbps = '0; cfg.s = '0; end
      endcase
      return cfg;
   endfunction

endpackage

// File: rtl/phy_rx_deinterleaver_addr_gen.sv
// Combinational inverse-interleaver address: received index j -> encoder index k
// for the symbol size ncbps and rotation span s.
module phy_rx_deinterleaver_addr_gen
   import phy_rx_deinterleaver_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0] j_i,
   input  logic [ADDR_W-1:0] ncbps_i,
   input  logic [1:0]        s_i,
   output logic [ADDR_W-1:0] k_o
);

   logic [CALC_W-1:0] j, n, s, f, i, q, k;

   always_comb begin
      j = CALC_W'(j_i);
      n = CALC_W'(ncbps_i);
      s = CALC_W'(s_i);
      // Keep the dividers well defined while no valid rate is latched.
      if (n == '0) n = CALC_W'(1);
      if (s == '0) s = CALC_W'(1);
      f   = (j << 4) / n;
      i   = s * (j / s) + (j + f) % s;
      q   = (i << 4) / n;
      k   = (i << 4) - (n - CALC_W'(1)) * q;
      k_o = ADDR_W'(k);
   end

endmodule

// File: rtl/phy_rx_deinterleaver.sv
// 802.11a receive deinterleaver: writes each symbol into a ping-pong bank at its
// encoder position and streams the bank out sequentially while the next one fills.
module phy_rx_deinterleaver
   import phy_rx_deinterleaver_pkg::*;
#(
   parameter int MAX_NCBPS = MAX_NCBPS_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       frame_start_i,
   input  logic [3:0] rate_i,
   input  logic       data_in_i,
   input  logic       data_in_valid_i,
   output logic       data_out_o,
   output logic       data_out_valid_o,
   output logic       symbol_done_o,
   output logic       rate_err_o
);

   rate_cfg_t         new_cfg;
   logic [ADDR_W-1:0] ncbps_q;
   logic [1:0]        s_q;
   logic              active_q, rate_err_q;
   logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q;
   logic              wr_bank_q, wr_bank_d, rd_bank_q;
   logic [1:0]        full_q, full_d;
   logic [MAX_NCBPS-1:0] bank_q [2];
   rd_state_t         state_q;
   logic              data_out_q, data_out_valid_q, symbol_done_q;

   logic [ADDR_W-1:0] ag_j, ag_n, wr_addr;
   logic [1:0]        ag_s;
   logic              wr_en, wr_sel, rd_last;

   assign new_cfg = decode_rate(rate_i);

   phy_rx_deinterleaver_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .j_i     (ag_j),
      .ncbps_i (ag_n),
      .s_i     (ag_s),
      .k_o     (wr_addr)
   );

   // On frame_start the incoming bit is already j=0 of the new frame at the new rate.
   always_comb begin
      rd_last   = (state_q == ST_READ) && (rd_cnt_q == ncbps_q - ADDR_W'(1));
      wr_sel    = frame_start_i ? 1'b0 : wr_bank_q;
      ag_j      = frame_start_i ? '0 : wr_cnt_q;
      ag_n      = frame_start_i ? ADDR_W'(new_cfg.ncbps) : ncbps_q;
      ag_s      = frame_start_i ? new_cfg.s : s_q;
      wr_en     = data_in_valid_i && (frame_start_i ? new_cfg.ok : active_q);
      wr_cnt_d  = ag_j;
      wr_bank_d = wr_sel;
      full_d    = frame_start_i ? 2'b00 : full_q;
      if (rd_last && !frame_start_i) full_d[rd_bank_q] = 1'b0;
      if (wr_en) begin
         if (ag_j == ag_n - ADDR_W'(1)) begin
            wr_cnt_d       = '0;
            full_d[wr_sel] = 1'b1;
            wr_bank_d      = ~wr_sel;
         end else begin
            wr_cnt_d = ag_j + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ncbps_q    <= '0;
         s_q        <= '0;
         active_q   <= 1'b0;
         rate_err_q <= 1'b0;
         wr_cnt_q   <= '0;
         wr_bank_q  <= 1'b0;
         full_q     <= 2'b00;
         bank_q[0]  <= '0;
         bank_q[1]  <= '0;
      end else begin
         if (frame_start_i) begin
            ncbps_q    <= ADDR_W'(new_cfg.ncbps);
            s_q        <= new_cfg.s;
            active_q   <= new_cfg.ok;
            rate_err_q <= ~new_cfg.ok;
            bank_q[0]  <= '0;
            bank_q[1]  <= '0;
         end
         wr_cnt_q  <= wr_cnt_d;
         wr_bank_q <= wr_bank_d;
         full_q    <= full_d;
         if (wr_en) bank_q[wr_sel][wr_addr] <= data_in_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q          <= ST_IDLE;
         rd_cnt_q         <= '0;
         rd_bank_q        <= 1'b0;
         data_out_q       <= 1'b0;
         data_out_valid_q <= 1'b0;
         symbol_done_q    <= 1'b0;
      end else if (frame_start_i) begin
         state_q          <= ST_IDLE;
         rd_cnt_q         <= '0;
         rd_bank_q        <= 1'b0;
         data_out_q       <= 1'b0;
         data_out_valid_q <= 1'b0;
         symbol_done_q    <= 1'b0;
      end else begin
         data_out_q       <= 1'b0;
         data_out_valid_q <= 1'b0;
         symbol_done_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (full_q[rd_bank_q]) begin
                  state_q  <= ST_READ;
                  rd_cnt_q <= '0;
               end
            end
            ST_READ: begin
               data_out_q       <= bank_q[rd_bank_q][rd_cnt_q];
               data_out_valid_q <= 1'b1;
               if (rd_last) begin
                  symbol_done_q <= 1'b1;
                  rd_bank_q     <= ~rd_bank_q;
                  rd_cnt_q      <= '0;
                  // Continuing straight into a waiting bank keeps back-to-back output gap-free.
                  state_q       <= full_q[~rd_bank_q] ? ST_READ : ST_IDLE;
               end else begin
                  rd_cnt_q <= rd_cnt_q + ADDR_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign data_out_o       = data_out_q;
   assign data_out_valid_o = data_out_valid_q;
   assign symbol_done_o    = symbol_done_q;
   assign rate_err_o       = rate_err_q;

endmodule

// File: tb/tb_phy_rx_deinterleaver.sv
// Directed bench for phy_rx_deinterleaver: forward 802.11a interleaver model feeds
// the DUT and every output bit, timing and flag is checked against it.
module tb_phy_rx_deinterleaver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_start = 1'b0;
   logic [3:0] rate = 4'b0000;
   logic       data_in = 1'b0;
   logic       data_in_valid = 1'b0;
   logic       data_out, data_out_valid, symbol_done, rate_err;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int last_drv = 0;
   bit out_q[$];
   int vcyc_q[$];
   int sd_q[$];
   int lastdrv_q[$];

   phy_rx_deinterleaver dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .frame_start_i    (frame_start),
      .rate_i           (rate),
      .data_in_i        (data_in),
      .data_in_valid_i  (data_in_valid),
      .data_out_o       (data_out),
      .data_out_valid_o (data_out_valid),
      .symbol_done_o    (symbol_done),
      .rate_err_o       (rate_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (data_out_valid === 1'b1) begin
         out_q.push_back(data_out);
         vcyc_q.push_back(cyc);
      end
      if (symbol_done === 1'b1) sd_q.push_back(cyc);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic mon_clear();
      out_q.delete(); vcyc_q.delete(); sd_q.delete(); lastdrv_q.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         data_in_valid = 1'b0; frame_start = 1'b0; data_in = 1'b0;
      end
   endtask

   task automatic drive(input bit b, input bit fs, input logic [3:0] r);
      @(negedge clk);
      data_in = b; data_in_valid = 1'b1; frame_start = fs; rate = r;
      last_drv = cyc;
   endtask

   // Sends bits as one frame; optional random idle cycles between bits.
   task automatic send_stream(input bit bits[$], input logic [3:0] r, input int n, input bit gaps);
      for (int i = 0; i < bits.size(); i++) begin
         if (gaps && i > 0 && $urandom_range(0, 1) == 1) idle(1);
         drive(bits[i], i == 0, r);
         if ((i + 1) % n == 0) lastdrv_q.push_back(last_drv);
      end
   endtask

   // Forward (transmit) interleaver: encoder index k -> transmitted index j.
   function automatic int fwd(input int k, input int n, input int s);
      int i;
      i = (n / 16) * (k % 16) + k / 16;
      return s * (i / s) + (i + n - (16 * i) / n) % s;
   endfunction

   function automatic void build_tx(input bit orig[$], input int n, input int s, output bit tx[$]);
      tx = orig;
      for (int m = 0; m < orig.size() / n; m++)
         for (int k = 0; k < n; k++) tx[m * n + fwd(k, n, s)] = orig[m * n + k];
   endfunction

   function automatic int ones(input bit q[$]);
      int c = 0;
      foreach (q[i]) c += int'(q[i]);
      return c;
   endfunction

   function automatic int diffs(input bit a[$], input bit b[$]);
      int c = 0;
      for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) c++;
      return c;
   endfunction

   initial begin
      bit orig[$];
      bit tx[$];
      bit one_hot[$];

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_outputs", {data_out, data_out_valid, symbol_done, rate_err}, 0);
      rst_n = 1'b1;
      idle(3);
      check("idle_no_valid", out_q.size(), 0);

      // 1: BPSK, single one at j=1 -> k=16
      mon_clear();
      one_hot = {};
      for (int i = 0; i < 48; i++) one_hot.push_back(i == 1);
      send_stream(one_hot, 4'b1101, 48, 1'b0);
      idle(60);
      check("t1_count", out_q.size(), 48);
      check("t1_k16", out_q[16], 1);
      check("t1_ones", ones(out_q), 1);
      check("t1_latency", vcyc_q[0], lastdrv_q[0] + 3);
      check("t1_contig", vcyc_q[47] - vcyc_q[0], 47);
      check("t1_sd_count", sd_q.size(), 1);
      check("t1_sd_pos", sd_q[0], vcyc_q[47]);

      // 2: 16-QAM, one at j=12 then (next symbol) one at j=2
      mon_clear();
      one_hot = {};
      for (int i = 0; i < 384; i++) one_hot.push_back(i == 12 || i == 192 + 2);
      send_stream(one_hot, 4'b1011, 192, 1'b0);
      idle(200);
      check("t2_count", out_q.size(), 384);
      check("t2_k17", out_q[17], 1);
      check("t2_k32", out_q[192 + 32], 1);
      check("t2_ones", ones(out_q), 2);
      check("t2_contig", vcyc_q[383] - vcyc_q[0], 383);

      // 3: 64-QAM, three back-to-back random symbols
      mon_clear();
      orig = {};
      for (int i = 0; i < 864; i++) orig.push_back(1'($urandom));
      build_tx(orig, 288, 3, tx);
      send_stream(tx, 4'b0001, 288, 1'b0);
      idle(300);
      check("t3_count", out_q.size(), 864);
      check("t3_data", diffs(out_q, orig), 0);
      check("t3_contig", vcyc_q[863] - vcyc_q[0], 863);
      check("t3_sd_count", sd_q.size(), 3);
      check("t3_latency", vcyc_q[0], lastdrv_q[0] + 3);

      // 4: QPSK with random input gaps
      mon_clear();
      orig = {};
      for (int i = 0; i < 192; i++) orig.push_back(1'($urandom));
      build_tx(orig, 96, 1, tx);
      send_stream(tx, 4'b0101, 96, 1'b1);
      idle(120);
      check("t4_count", out_q.size(), 192);
      check("t4_data", diffs(out_q, orig), 0);
      for (int m = 0; m < 2; m++) begin
         check("t4_sym_latency", vcyc_q[m * 96], lastdrv_q[m] + 3);
         check("t4_sym_contig", vcyc_q[m * 96 + 95] - vcyc_q[m * 96], 95);
      end

      // 5: abort a 192-bit symbol at bit 100, restart at BPSK
      mon_clear();
      tx = {};
      for (int i = 0; i < 100; i++) tx.push_back(1'b1);
      send_stream(tx, 4'b1001, 192, 1'b0);
      one_hot = {};
      for (int i = 0; i < 48; i++) one_hot.push_back(i == 1);
      send_stream(one_hot, 4'b1101, 48, 1'b0);
      idle(60);
      check("t5_count", out_q.size(), 48);
      check("t5_k16", out_q[16], 1);
      check("t5_ones", ones(out_q), 1);

      // 6: unsupported rate, then reset mid-read
      mon_clear();
      tx = {};
      for (int i = 0; i < 48; i++) tx.push_back(1'b1);
      send_stream(tx, 4'b0000, 48, 1'b0);
      idle(60);
      check("t6_rate_err", rate_err, 1);
      check("t6_no_valid", out_q.size(), 0);
      send_stream(tx, 4'b1101, 48, 1'b0);
      idle(10);
      check("t6_rate_err_clr", rate_err, 0);
      check("t6_reading", data_out_valid, 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_in_reset", {data_out, data_out_valid, symbol_done, rate_err}, 0);
      idle(2);
      rst_n = 1'b1;
      mon_clear();
      idle(60);
      check("t6_post_reset_valid", out_q.size(), 0);
      check("t6_post_reset_sd", sd_q.size(), 0);
      check("t6_post_reset_out", {data_out, data_out_valid, symbol_done, rate_err}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
